// File: rtl/datapath_seq_pkg.sv
// Shared constants for the datapath sequencer: state codes, opcodes, ALU op codes, IR fields.
package datapath_seq_pkg;

  localparam int unsigned OpcW   = 5;
  localparam int unsigned RegW   = 4;
  localparam int unsigned AluOpW = 4;

  typedef logic [3:0] state_t;
  localparam state_t StIdle = 4'd0;
  localparam state_t StT0   = 4'd1;
  localparam state_t StT1   = 4'd2;
  localparam state_t StT1W  = 4'd3;
  localparam state_t StT2   = 4'd4;
  localparam state_t StT3   = 4'd5;
  localparam state_t StT4   = 4'd6;
  localparam state_t StT5   = 4'd7;
  localparam state_t StT6   = 4'd8;

  localparam logic [OpcW-1:0] OpAdd  = 5'b00011;
  localparam logic [OpcW-1:0] OpSub  = 5'b00100;
  localparam logic [OpcW-1:0] OpAnd  = 5'b00101;
  localparam logic [OpcW-1:0] OpOr   = 5'b00110;
  localparam logic [OpcW-1:0] OpShr  = 5'b00111;
  localparam logic [OpcW-1:0] OpShra = 5'b01000;
  localparam logic [OpcW-1:0] OpShl  = 5'b01001;
  localparam logic [OpcW-1:0] OpRor  = 5'b01010;
  localparam logic [OpcW-1:0] OpRol  = 5'b01011;
  localparam logic [OpcW-1:0] OpMul  = 5'b01111;
  localparam logic [OpcW-1:0] OpDiv  = 5'b10000;

  localparam logic [AluOpW-1:0] AluPass = 4'd0;
  localparam logic [AluOpW-1:0] AluAdd  = 4'd1;
  localparam logic [AluOpW-1:0] AluSub  = 4'd2;
  localparam logic [AluOpW-1:0] AluAnd  = 4'd3;
  localparam logic [AluOpW-1:0] AluOr   = 4'd4;
  localparam logic [AluOpW-1:0] AluShr  = 4'd5;
  localparam logic [AluOpW-1:0] AluShra = 4'd6;
  localparam logic [AluOpW-1:0] AluShl  = 4'd7;
  localparam logic [AluOpW-1:0] AluRor  = 4'd8;
  localparam logic [AluOpW-1:0] AluRol  = 4'd9;
  localparam logic [AluOpW-1:0] AluMul  = 4'd10;
  localparam logic [AluOpW-1:0] AluDiv  = 4'd11;

  localparam int unsigned OpcLsb = 27;
  localparam int unsigned RaLsb  = 23;
  localparam int unsigned RbLsb  = 19;
  localparam int unsigned RcLsb  = 15;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decode: legality, HI/LO class and ALU function code.
module seq_decode
  import datapath_seq_pkg::*;
(
  input  logic [OpcW-1:0]   opcode_i,
  output logic              legal_o,
  output logic              is_hilo_o,
  output logic [AluOpW-1:0] alu_op_o
);

  always_comb begin
    legal_o   = 1'b1;
    is_hilo_o = 1'b0;
    alu_op_o  = AluPass;
    case (opcode_i)
      OpAdd:  alu_op_o = AluAdd;
      OpSub:  alu_op_o = AluSub;
      OpAnd:  alu_op_o = AluAnd;
      OpOr:   alu_op_o = AluOr;
      OpShr:  alu_op_o = AluShr;
      OpShra: alu_op_o = AluShra;
      OpShl:  alu_op_o = AluShl;
      OpRor:  alu_op_o = AluRor;
      OpRol:  alu_op_o = AluRol;
      OpMul: begin
        alu_op_o  = AluMul;
        is_hilo_o = 1'b1;
      end
      OpDiv: begin
        alu_op_o  = AluDiv;
        is_hilo_o = 1'b1;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Moore control FSM for fetch/execute of register-register ALU and mul/div instructions.
// Optional single-step gating via the DATAPATH_SEQ_STEP_EN macro (adds input step).
module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int unsigned OPC_W   = 5,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic               Clock,
  input  logic               clear,
  input  logic               run,
  input  logic               mem_ready,
`ifdef DATAPATH_SEQ_STEP_EN
  input  logic               step,
`endif
  input  logic [31:0]        ir,
  output logic               PCout,
  output logic               Zlowout,
  output logic               Zhighout,
  output logic               MDRout,
  output logic               MARin,
  output logic               PCin,
  output logic               MDRin,
  output logic               IRin,
  output logic               Yin,
  output logic               Zin_low,
  output logic               Zin_high,
  output logic               HIin,
  output logic               LOin,
  output logic               IncPC,
  output logic               Read,
  output logic               reg_out_en,
  output logic [REG_W-1:0]   reg_out_sel,
  output logic               reg_in_en,
  output logic [REG_W-1:0]   reg_in_sel,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  state_t state_q, state_d, state_nx;
  logic   illegal_q, illegal_d;
  logic   step_ok;
  logic   legal, is_hilo;
  logic [AluOpW-1:0] dec_alu_op;

  logic [OPC_W-1:0] opcode;
  logic [REG_W-1:0] ra, rb, rc;
  logic             unused_ir;

  assign opcode    = ir[OpcLsb +: OPC_W];
  assign ra        = ir[RaLsb +: REG_W];
  assign rb        = ir[RbLsb +: REG_W];
  assign rc        = ir[RcLsb +: REG_W];
  assign unused_ir = ^ir[RcLsb-1:0];

`ifdef DATAPATH_SEQ_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  seq_decode u_decode (
    .opcode_i  (opcode),
    .legal_o   (legal),
    .is_hilo_o (is_hilo),
    .alu_op_o  (dec_alu_op)
  );

  always_comb begin
    state_nx = state_q;
    case (state_q)
      StIdle:  if (run) state_nx = StT0;
      StT0:    state_nx = StT1;
      StT1:    state_nx = StT1W;
      StT1W:   if (mem_ready) state_nx = StT2;
      StT2:    state_nx = StT3;
      StT3:    state_nx = legal ? StT4 : StIdle;
      StT4:    state_nx = StT5;
      StT5:    state_nx = is_hilo ? StT6 : (run ? StT0 : StIdle);
      StT6:    state_nx = run ? StT0 : StIdle;
      default: state_nx = StIdle;
    endcase
    // A held step freezes the state and therefore every strobe it decodes.
    state_d   = step_ok ? state_nx : state_q;
    illegal_d = illegal_q | (step_ok && (state_q == StT3) && !legal);
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    PCout       = 1'b0;
    Zlowout     = 1'b0;
    Zhighout    = 1'b0;
    MDRout      = 1'b0;
    MARin       = 1'b0;
    PCin        = 1'b0;
    MDRin       = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin_low     = 1'b0;
    Zin_high    = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    IncPC       = 1'b0;
    Read        = 1'b0;
    reg_out_en  = 1'b0;
    reg_out_sel = '0;
    reg_in_en   = 1'b0;
    reg_in_sel  = '0;
    alu_op      = '0;
    done        = 1'b0;
    case (state_q)
      StT0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin_low = 1'b1;
      end
      StT1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
      end
      StT1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        if (legal) begin
          reg_out_en  = 1'b1;
          reg_out_sel = rb;
          Yin         = 1'b1;
        end
      end
      StT4: begin
        reg_out_en  = 1'b1;
        reg_out_sel = rc;
        alu_op      = ALUOP_W'(dec_alu_op);
        Zin_low     = 1'b1;
        Zin_high    = is_hilo;
      end
      StT5: begin
        Zlowout = 1'b1;
        if (is_hilo) begin
          LOin = 1'b1;
        end else begin
          reg_in_en  = 1'b1;
          reg_in_sel = ra;
          done       = 1'b1;
        end
      end
      StT6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != StIdle);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench: the stimulus thread queues the expected output word per cycle and a
// negedge monitor compares every cycle's outputs against the queue head.
module tb_datapath_sequencer;

  logic        Clock = 1'b0;
  logic        clear = 1'b1;
  logic        run = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = 32'h0;
`ifdef DATAPATH_SEQ_STEP_EN
  logic        step = 1'b1;
`endif
  logic PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin;
  logic Zin_low, Zin_high, HIin, LOin, IncPC, Read;
  logic       reg_out_en, reg_in_en, busy, done, illegal;
  logic [3:0] reg_out_sel, reg_in_sel, alu_op;

  datapath_sequencer dut (
    .Clock       (Clock),
    .clear       (clear),
    .run         (run),
    .mem_ready   (mem_ready),
`ifdef DATAPATH_SEQ_STEP_EN
    .step        (step),
`endif
    .ir          (ir),
    .PCout       (PCout),
    .Zlowout     (Zlowout),
    .Zhighout    (Zhighout),
    .MDRout      (MDRout),
    .MARin       (MARin),
    .PCin        (PCin),
    .MDRin       (MDRin),
    .IRin        (IRin),
    .Yin         (Yin),
    .Zin_low     (Zin_low),
    .Zin_high    (Zin_high),
    .HIin        (HIin),
    .LOin        (LOin),
    .IncPC       (IncPC),
    .Read        (Read),
    .reg_out_en  (reg_out_en),
    .reg_out_sel (reg_out_sel),
    .reg_in_en   (reg_in_en),
    .reg_in_sel  (reg_in_sel),
    .alu_op      (alu_op),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 Clock = ~Clock;

  localparam logic [31:0] M_PCOUT  = 32'h8000_0000;
  localparam logic [31:0] M_ZLOUT  = 32'h4000_0000;
  localparam logic [31:0] M_ZHOUT  = 32'h2000_0000;
  localparam logic [31:0] M_MDROUT = 32'h1000_0000;
  localparam logic [31:0] M_MARIN  = 32'h0800_0000;
  localparam logic [31:0] M_PCIN   = 32'h0400_0000;
  localparam logic [31:0] M_MDRIN  = 32'h0200_0000;
  localparam logic [31:0] M_IRIN   = 32'h0100_0000;
  localparam logic [31:0] M_YIN    = 32'h0080_0000;
  localparam logic [31:0] M_ZINL   = 32'h0040_0000;
  localparam logic [31:0] M_ZINH   = 32'h0020_0000;
  localparam logic [31:0] M_HIIN   = 32'h0010_0000;
  localparam logic [31:0] M_LOIN   = 32'h0008_0000;
  localparam logic [31:0] M_INCPC  = 32'h0004_0000;
  localparam logic [31:0] M_READ   = 32'h0002_0000;
  localparam logic [31:0] M_BUSY   = 32'h0000_0004;
  localparam logic [31:0] M_DONE   = 32'h0000_0002;
  localparam logic [31:0] M_ILL    = 32'h0000_0001;

  localparam logic [31:0] E_T0  = M_PCOUT | M_MARIN | M_INCPC | M_ZINL | M_BUSY;
  localparam logic [31:0] E_T1  = M_ZLOUT | M_PCIN | M_READ | M_BUSY;
  localparam logic [31:0] E_T1W = M_READ | M_MDRIN | M_BUSY;
  localparam logic [31:0] E_T2  = M_MDROUT | M_IRIN | M_BUSY;

  logic [31:0] act;
  assign act = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin_low,
                Zin_high, HIin, LOin, IncPC, Read, reg_out_en, reg_out_sel, reg_in_en,
                reg_in_sel, alu_op, busy, done, illegal};

  typedef struct {
    logic [31:0] v;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] ill_exp = 32'h0;

  function automatic logic [31:0] f_ros(input logic [3:0] r);
    return {15'b0, 1'b1, r, 12'b0};
  endfunction
  function automatic logic [31:0] f_ris(input logic [3:0] r);
    return {20'b0, 1'b1, r, 7'b0};
  endfunction
  function automatic logic [31:0] f_aop(input logic [3:0] a);
    return {25'b0, a, 3'b0};
  endfunction

  task automatic chk(input logic [31:0] e, input string tag);
    exp_t x;
    @(posedge Clock);
    #1;
    x.v   = e | ill_exp;
    x.tag = tag;
    exp_q.push_back(x);
  endtask

  always @(negedge Clock) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      tests++;
      if (act !== x.v) begin
        fails++;
        $display("FAIL %s: got %08h expected %08h", x.tag, act, x.v);
      end
      tests++;
      if (!$onehot0({PCout, Zlowout, Zhighout, MDRout, reg_out_en})) begin
        fails++;
        $display("FAIL bus_onehot %s: sources %05b expected at most one set", x.tag,
                 {PCout, Zlowout, Zhighout, MDRout, reg_out_en});
      end
    end
  end

  // One full instruction starting from IDLE or a done state; run drops mid-flight.
  task automatic do_instr(input logic [4:0] opc, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] aop, input logic hilo,
                          input int stall, input logic cont);
    ir        = {opc, a, b, c, 15'b0};
    run       = 1'b1;
    mem_ready = 1'b0;
    chk(E_T0, "T0");
    run = 1'b0;
    chk(E_T1, "T1");
    chk(E_T1W, "T1W");
    repeat (stall) chk(E_T1W, "T1W_stall");
    mem_ready = 1'b1;
    chk(E_T2, "T2");
    mem_ready = 1'b0;
    chk(f_ros(b) | M_YIN | M_BUSY, "T3");
    chk(f_ros(c) | f_aop(aop) | M_ZINL | (hilo ? M_ZINH : 32'h0) | M_BUSY, "T4");
    if (hilo) begin
      chk(M_ZLOUT | M_LOIN | M_BUSY, "T5_hilo");
      run = cont;
      chk(M_ZHOUT | M_HIIN | M_DONE | M_BUSY, "T6");
    end else begin
      run = cont;
      chk(M_ZLOUT | f_ris(a) | M_DONE | M_BUSY, "T5");
    end
    if (!cont) chk(32'h0, "back_idle");
  endtask

  logic [4:0] opc_tab[11] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                              5'b01001, 5'b01010, 5'b01011, 5'b01111, 5'b10000};
  logic [3:0] aop_tab[11] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10,
                              4'd11};

  initial begin
    chk(32'h0, "clear1");
    chk(32'h0, "clear2");
    clear = 1'b0;
    repeat (10) chk(32'h0, "idle_run0");

    // add r1,r2,r3
    do_instr(5'b00011, 4'd1, 4'd2, 4'd3, 4'd1, 1'b0, 0, 1'b0);
    // mul r0,r4,r5 then straight into sub r7,r8,r9 with a 3-cycle memory stall
    do_instr(5'b01111, 4'd0, 4'd4, 4'd5, 4'd10, 1'b1, 0, 1'b1);
    do_instr(5'b00100, 4'd7, 4'd8, 4'd9, 4'd2, 1'b0, 3, 1'b0);

    for (int i = 2; i < 11; i++) begin
      do_instr(opc_tab[i], 4'(i), 4'((i + 5) % 16), 4'((i + 9) % 16), aop_tab[i],
               (i >= 9) ? 1'b1 : 1'b0, 0, 1'b0);
    end

    // same register in all three fields
    do_instr(5'b00110, 4'd6, 4'd6, 4'd6, 4'd4, 1'b0, 1, 1'b0);

    // unknown opcode
    ir        = 32'hF800_0000 | {5'b0, 4'd2, 4'd3, 4'd4, 15'b0};
    run       = 1'b1;
    mem_ready = 1'b1;
    chk(E_T0, "ill_T0");
    run = 1'b0;
    chk(E_T1, "ill_T1");
    chk(E_T1W, "ill_T1W");
    chk(E_T2, "ill_T2");
    chk(M_BUSY, "ill_T3");
    ill_exp = M_ILL;
    chk(32'h0, "ill_idle");
    chk(32'h0, "ill_sticky");
    clear   = 1'b1;
    ill_exp = 32'h0;
    chk(32'h0, "ill_cleared");
    clear     = 1'b0;
    mem_ready = 1'b0;

    // clear during T4 abandons the instruction
    ir        = {5'b00011, 4'd1, 4'd2, 4'd3, 15'b0};
    run       = 1'b1;
    mem_ready = 1'b1;
    chk(E_T0, "clr_T0");
    chk(E_T1, "clr_T1");
    chk(E_T1W, "clr_T1W");
    chk(E_T2, "clr_T2");
    chk(f_ros(4'd2) | M_YIN | M_BUSY, "clr_T3");
    chk(f_ros(4'd3) | f_aop(4'd1) | M_ZINL | M_BUSY, "clr_T4");
    clear = 1'b1;
    run   = 1'b0;
    chk(32'h0, "clr_idle");
    clear = 1'b0;
    chk(32'h0, "clr_idle2");

`ifdef DATAPATH_SEQ_STEP_EN
    run = 1'b1;
    chk(E_T0, "step_T0");
    step = 1'b0;
    run  = 1'b0;
    repeat (5) chk(E_T0, "step_hold");
    step = 1'b1;
    chk(E_T1, "step_T1");
    mem_ready = 1'b1;
    step      = 1'b0;
    chk(E_T1W, "step_T1W");
    chk(E_T1W, "step_T1W_hold");
    clear = 1'b1;
    chk(32'h0, "step_clear");
    clear     = 1'b0;
    step      = 1'b1;
    mem_ready = 1'b0;
`endif

    repeat (2) @(negedge Clock);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
